// File: rtl/corelet_ctrl_if.sv
// rtl/corelet_ctrl_if.sv - control and SRAM-address bundle between corelet_ctrl and the corelet
// master = sequencer side, slave = corelet/SRAM side.
interface corelet_ctrl_if #(parameter int AW = 8);
    logic          start;
    logic          busy;
    logic          done;
    logic          w_cen;
    logic [AW-1:0] w_addr;
    logic          w_valid;
    logic          l0_rd;
    logic [1:0]    inst_w;
    logic          a_cen;
    logic [AW-1:0] a_addr;
    logic          act_valid;
    logic          ofifo_valid;
    logic          ofifo_rd;
    logic          p_cen;
    logic [AW-1:0] p_raddr;
    logic          old_psum_valid;
    logic [AW-1:0] p_waddr;

    modport master (
        input  start, ofifo_valid,
        output busy, done, w_cen, w_addr, w_valid, l0_rd, inst_w, a_cen, a_addr,
               act_valid, ofifo_rd, p_cen, p_raddr, old_psum_valid, p_waddr
    );

    modport slave (
        output start, ofifo_valid,
        input  busy, done, w_cen, w_addr, w_valid, l0_rd, inst_w, a_cen, a_addr,
               act_valid, ofifo_rd, p_cen, p_raddr, old_psum_valid, p_waddr
    );
endinterface

// File: rtl/corelet_ctrl.sv
// rtl/corelet_ctrl.sv - per-tile sequencer: weight load, kernel load, activation stream, OFIFO drain
// One pass of LOAD_W/KLOAD/EXEC/DRAIN per kernel position; psums accumulate in PSUM SRAM.
module corelet_ctrl #(
    parameter int ROW     = 8,
    parameter int COL     = 8,
    parameter int N_KIJ   = 9,
    parameter int N_ACT   = 36,
    parameter int N_OUT   = 16,
    parameter int SFP_LAT = 1,
    parameter int AW      = 8
) (
    input  logic           clk,
    input  logic           reset,
    corelet_ctrl_if.master bus
);
    localparam logic [15:0]   LOADW_LAST = 16'(ROW - 1);
    localparam logic [15:0]   KLOAD_LAST = 16'(ROW + COL - 2);
    localparam logic [15:0]   L0_CYCLES  = 16'(ROW);
    localparam logic [15:0]   EXEC_LAST  = 16'(N_ACT - 1);
    localparam logic [15:0]   FLUSH_LAST = 16'(SFP_LAT);
    localparam logic [15:0]   KIJ_LAST   = 16'(N_KIJ - 1);
    localparam logic [AW-1:0] BEAT_LAST  = AW'(N_OUT - 1);
    localparam logic [AW-1:0] ROW_STEP   = AW'(ROW);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_W, S_KLOAD, S_EXEC, S_DRAIN, S_FLUSH, S_FIN
    } state_t;

    state_t        r_state;
    logic [15:0]   r_phase;
    logic [15:0]   r_kij;
    logic [AW-1:0] r_base;
    logic [AW-1:0] r_beat;
    logic          r_busy;
    logic          r_done;
    logic          r_w_cen;
    logic [AW-1:0] r_w_addr;
    logic          r_l0_rd;
    logic [1:0]    r_inst_w;
    logic          r_a_cen;
    logic [AW-1:0] r_a_addr;
    logic          r_w_valid;
    logic          r_act_valid;
    logic          r_old_psum_valid;
    logic [AW-1:0] r_wa_pipe [SFP_LAT+1];

    logic          w_drain;
    logic          w_ofifo_rd;
    logic          w_p_cen;
    logic [AW-1:0] w_p_raddr;

    // Drain-side strobes follow ofifo_valid combinationally so a read never fires on an empty OFIFO.
    assign w_drain    = (r_state == S_DRAIN);
    assign w_ofifo_rd = w_drain && bus.ofifo_valid;
    assign w_p_cen    = !(w_ofifo_rd && (r_kij != 16'd0));
    assign w_p_raddr  = w_drain ? r_beat : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_phase  <= '0;
            r_kij    <= '0;
            r_base   <= '0;
            r_beat   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_w_cen  <= 1'b1;
            r_w_addr <= '0;
            r_l0_rd  <= 1'b0;
            r_inst_w <= 2'b00;
            r_a_cen  <= 1'b1;
            r_a_addr <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state  <= S_LOAD_W;
                        r_phase  <= '0;
                        r_kij    <= '0;
                        r_base   <= '0;
                        r_busy   <= 1'b1;
                        r_w_cen  <= 1'b0;
                        r_w_addr <= '0;
                    end
                end
                S_LOAD_W: begin
                    if (r_phase == LOADW_LAST) begin
                        r_state  <= S_KLOAD;
                        r_phase  <= '0;
                        r_w_cen  <= 1'b1;
                        r_inst_w <= 2'b01;
                        r_l0_rd  <= 1'b1;
                    end else begin
                        r_phase  <= r_phase + 16'd1;
                        r_w_addr <= r_w_addr + AW'(1);
                    end
                end
                S_KLOAD: begin
                    if (r_phase == KLOAD_LAST) begin
                        r_state  <= S_EXEC;
                        r_phase  <= '0;
                        r_l0_rd  <= 1'b0;
                        r_inst_w <= 2'b10;
                        r_a_cen  <= 1'b0;
                        r_a_addr <= '0;
                    end else begin
                        r_phase <= r_phase + 16'd1;
                        r_l0_rd <= ((r_phase + 16'd1) < L0_CYCLES);
                    end
                end
                S_EXEC: begin
                    if (r_phase == EXEC_LAST) begin
                        r_state  <= S_DRAIN;
                        r_phase  <= '0;
                        r_inst_w <= 2'b00;
                        r_a_cen  <= 1'b1;
                        r_beat   <= '0;
                    end else begin
                        r_phase  <= r_phase + 16'd1;
                        r_a_addr <= r_a_addr + AW'(1);
                    end
                end
                S_DRAIN: begin
                    if (bus.ofifo_valid) begin
                        if (r_beat != BEAT_LAST) begin
                            r_beat <= r_beat + AW'(1);
                        end else if (r_kij == KIJ_LAST) begin
                            r_state <= S_FLUSH;
                            r_phase <= '0;
                        end else begin
                            // Base register replaces the kij*row multiply.
                            r_state  <= S_LOAD_W;
                            r_phase  <= '0;
                            r_kij    <= r_kij + 16'd1;
                            r_base   <= r_base + ROW_STEP;
                            r_w_cen  <= 1'b0;
                            r_w_addr <= r_base + ROW_STEP;
                        end
                    end
                end
                S_FLUSH: begin
                    if (r_phase == FLUSH_LAST) begin
                        r_state <= S_FIN;
                        r_done  <= 1'b1;
                    end else begin
                        r_phase <= r_phase + 16'd1;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // SRAM read data lands one cycle after its enable; p_waddr trails the read address by SFP_LAT+1.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_w_valid        <= 1'b0;
            r_act_valid      <= 1'b0;
            r_old_psum_valid <= 1'b0;
            for (int i = 0; i <= SFP_LAT; i++) r_wa_pipe[i] <= '0;
        end else begin
            r_w_valid        <= !r_w_cen;
            r_act_valid      <= !r_a_cen;
            r_old_psum_valid <= !w_p_cen;
            r_wa_pipe[0]     <= w_p_raddr;
            for (int i = 1; i <= SFP_LAT; i++) r_wa_pipe[i] <= r_wa_pipe[i-1];
        end
    end

    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.w_cen          = r_w_cen;
    assign bus.w_addr         = r_w_addr;
    assign bus.w_valid        = r_w_valid;
    assign bus.l0_rd          = r_l0_rd;
    assign bus.inst_w         = r_inst_w;
    assign bus.a_cen          = r_a_cen;
    assign bus.a_addr         = r_a_addr;
    assign bus.act_valid      = r_act_valid;
    assign bus.ofifo_rd       = w_ofifo_rd;
    assign bus.p_cen          = w_p_cen;
    assign bus.p_raddr        = w_p_raddr;
    assign bus.old_psum_valid = r_old_psum_valid;
    assign bus.p_waddr        = r_wa_pipe[SFP_LAT];
endmodule
